text_column_renderer: RTL
=========================

Name: text_column_renderer

Overview:
- Scans a COLS x ROWS character text buffer and turns it into a stream of 8-bit pixel columns for the LCD column writer.
- For each character cell it reads the code from the text RAM, then steps the 5x7 font ROM through columns 0..5; column 5 is the blank inter-character gap, which the font ROM returns as 0x00.
- Sits between the text buffer and font ROM upstream and the LCD write sequencer downstream.
- Adds a blinking cursor by inverting one cell.

Parameters:
- COLS, 40, characters per text row. Each row is COLS*6 = 240 pixel columns.
- ROWS, 8, text rows, one per 8-pixel LCD page.
- BLINK_FRAMES, 16, number of completed frames per cursor blink phase toggle.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  begin one frame scan; sampled only in IDLE
- busy  out  1  high from the cycle after start is accepted until frame_done
- frame_done  out  1  one-cycle pulse after the last column of the last row is accepted
- text_addr  out  9  text RAM address = row*COLS + chr; RAM output is registered, 1-cycle latency
- text_data  in  7  character code from text RAM
- character  out  7  code to font ROM
- col  out  3  font column 0..5 to font ROM
- pixels  in  8  font ROM output; registered, valid the cycle after character/col change
- cursor_en  in  1  enable cursor display
- cursor_row  in  3  cursor row
- cursor_chr  in  6  cursor character position
- out_valid  out  1  out_data/out_row/out_x are valid
- out_ready  in  1  downstream accepts when out_valid && out_ready
- out_data  out  8  pixel column, bit 0 = top
- out_row  out  3  text row / LCD page of this column
- out_x  out  8  pixel column 0..COLS*6-1 within the row

Behaviour:
- Reset: state IDLE. busy=0, frame_done=0, out_valid=0, out_data=0, out_row=0, out_x=0, text_addr=0, character=0x20, col=0. Blink phase=0, frame counter=0. A reset mid-frame abandons the frame with no frame_done pulse.
- FSM states: IDLE, FETCH, LATCH, FONT_REQ, FONT_WAIT, EMIT, DONE.
- IDLE: if start, clear row/chr/col and go to FETCH. A start while not in IDLE is ignored.
- FETCH: drive text_addr, 1 cycle.
- LATCH: register text_data into character. Codes <0x20 or ==0x7F are substituted with 0x20 (space), because the font ROM only covers 0x20..0x7E. Then go to FONT_REQ.
- FONT_REQ: col is stable, 1 cycle.
- FONT_WAIT: capture pixels into out_data. Apply inversion (out_data = ~pixels) when cursor_en && blink phase==1 && row==cursor_row && chr==cursor_chr; inversion covers all 6 columns including the gap. Set out_valid=1 and go to EMIT.
- EMIT: hold out_valid and all outputs stable until out_ready. out_valid never drops without acceptance. On acceptance:
  - col<5: col+1, out_x+1, go to FONT_REQ.
  - col==5 and chr<COLS-1: chr+1, col=0, go to FETCH.
  - col==5, chr==COLS-1, row<ROWS-1: row+1, chr=0, out_x=0, go to FETCH.
  - Otherwise go to DONE.
- DONE: pulse frame_done for 1 cycle, busy=0, return to IDLE. Increment the frame counter; when it reaches BLINK_FRAMES-1 it wraps to 0 and toggles the blink phase.
- Cursor inputs are sampled in FONT_WAIT. Out-of-range cursor positions simply never match.
- Timing with out_ready held high:
  - Column cost: 3 cycles each.
  - Character cost: 20 cycles (2 fetch + 6*3).
  - Frame cost: ROWS*COLS*20 = 6400 cycles at default parameters; frame_done follows 1 cycle after the final acceptance.
- Width rules:
  - text_addr computed in 9 bits; ROWS*COLS must be ≤ 512.
  - out_x ≤ 239.
  - Row and chr counters never exceed ROWS-1 / COLS-1.

Decomposition:
- Shared package holds:
  - FSM state enum.
  - FONT_FIRST=0x20, FONT_LAST=0x7E, SPACE=0x20.
  - GLYPH_COLS=6.
- Natural sub-module: cursor_blink (frame counter plus phase toggle, with inputs frame_done and reset).
- The FSM and counters stay in the top level.

Test Plan:
- Text RAM all 0x41 ('A'), out_ready=1, start pulse -> 1920 columns, out_x 0..239 per row, out_row 0..7; frame_done exactly 6400 cycles after the start cycle (±1 per the FSM); every col-5 output is 0x00.
- Cell (0,0)=0x07 and cell (0,1)=0x7F -> font sees character=0x20 for both; out_data=0x00 for columns 0..11.
- out_ready toggled randomly (50%) -> no column lost or duplicated; outputs stable while out_valid && !out_ready; column sequence matches the ready=1 run.
- cursor_en=1, cursor_row=2, cursor_chr=5, run 2*BLINK_FRAMES frames -> frames 0..15 have no inversion; frames 16..31 have out_x 30..35 of row 2 inverted (gap column = 0xFF).
- Assert reset mid-frame at row 3 -> next cycle out_valid=0, busy=0, no frame_done. A subsequent start restarts at row 0, out_x 0.
- start held high continuously -> back-to-back frames with one IDLE cycle between them; start asserted during busy has no effect.

Source files
------------

// File: rtl/text_column_renderer_pkg.sv
// rtl/text_column_renderer_pkg.sv - shared state type and font constants for the text column renderer
package text_column_renderer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LATCH,
    FONT_REQ,
    FONT_WAIT,
    EMIT,
    DONE
  } state_t;

  localparam logic [6:0] FONT_FIRST = 7'h20;
  localparam logic [6:0] FONT_LAST  = 7'h7E;
  localparam logic [6:0] SPACE      = 7'h20;
  localparam logic [2:0] GLYPH_COLS = 3'd6;

  // The font ROM has no glyphs for control codes or DEL; show them as blanks.
  function automatic logic [6:0] font_code(input logic [6:0] code);
    return (code < FONT_FIRST || code > FONT_LAST) ? SPACE : code;
  endfunction

endpackage

// File: rtl/text_column_renderer_cursor_blink.sv
// rtl/text_column_renderer_cursor_blink.sv - counts completed frames and toggles the cursor blink phase
module text_column_renderer_cursor_blink #(
  parameter int BLINK_FRAMES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic frame_done,
  output logic phase
);

  localparam int CW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [CW-1:0] frame_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      frame_cnt <= '0;
      phase     <= 1'b0;
    end else if (frame_done) begin
      if (frame_cnt == CW'(BLINK_FRAMES - 1)) begin
        frame_cnt <= '0;
        phase     <= ~phase;
      end else begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/text_column_renderer.sv
// rtl/text_column_renderer.sv - scans the text buffer through the font ROM into a stream of LCD pixel columns
module text_column_renderer
  import text_column_renderer_pkg::*;
#(
  parameter int COLS         = 40,
  parameter int ROWS         = 8,
  parameter int BLINK_FRAMES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       busy,
  output logic       frame_done,
  output logic [8:0] text_addr,
  input  logic [6:0] text_data,
  output logic [6:0] character,
  output logic [2:0] col,
  input  logic [7:0] pixels,
  input  logic       cursor_en,
  input  logic [2:0] cursor_row,
  input  logic [5:0] cursor_chr,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic [2:0] out_row,
  output logic [7:0] out_x
);

  state_t     state, state_next;
  logic [2:0] row;
  logic [5:0] chr;
  logic       phase;
  logic       last_col, last_chr, last_row, cursor_hit;

  assign last_col   = (col == GLYPH_COLS - 3'd1);
  assign last_chr   = (chr == 6'(COLS - 1));
  assign last_row   = (row == 3'(ROWS - 1));
  assign cursor_hit = cursor_en && phase && (cursor_row == row) && (cursor_chr == chr);

  assign text_addr  = 9'(row) * 9'(COLS) + 9'(chr);
  assign out_row    = row;
  assign out_valid  = (state == EMIT);
  assign frame_done = (state == DONE);
  assign busy       = (state != IDLE) && (state != DONE);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (start) state_next = FETCH;
      FETCH:     state_next = LATCH;
      LATCH:     state_next = FONT_REQ;
      FONT_REQ:  state_next = FONT_WAIT;
      FONT_WAIT: state_next = EMIT;
      EMIT: begin
        if (out_ready) begin
          if (!last_col)                  state_next = FONT_REQ;
          else if (last_chr && last_row)  state_next = DONE;
          else                            state_next = FETCH;
        end
      end
      DONE:      state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      row       <= '0;
      chr       <= '0;
      col       <= '0;
      out_x     <= '0;
      out_data  <= '0;
      character <= SPACE;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            row   <= '0;
            chr   <= '0;
            col   <= '0;
            out_x <= '0;
          end
        end
        LATCH:     character <= font_code(text_data);
        FONT_WAIT: out_data  <= cursor_hit ? ~pixels : pixels;
        EMIT: begin
          // Counters only move on acceptance so the presented column stays put while stalled.
          if (out_ready) begin
            if (!last_col) begin
              col   <= col + 3'd1;
              out_x <= out_x + 8'd1;
            end else if (!last_chr) begin
              chr   <= chr + 6'd1;
              col   <= '0;
              out_x <= out_x + 8'd1;
            end else if (!last_row) begin
              row   <= row + 3'd1;
              chr   <= '0;
              col   <= '0;
              out_x <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  text_column_renderer_cursor_blink #(
    .BLINK_FRAMES(BLINK_FRAMES)
  ) u_cursor_blink (
    .clk        (clk),
    .reset      (reset),
    .frame_done (frame_done),
    .phase      (phase)
  );

endmodule
